// File: rtl/mips_run_ctrl.sv
// Host-side byte-command sequencer for the MIPS core: imem load, run, single-step, clear, report.
// Optional run watchdog is compiled in with `define MIPS_RUN_WDOG_EN.
module mips_run_ctrl #(
  parameter int IMEM_AW        = 8,
  parameter int CYCLE_W        = 32,
  parameter int MAX_RUN_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               cpu_en,
  output logic               cpu_reset,
  input  logic               cpu_halt,
  input  logic [31:0]        cpu_result,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_CNT, S_LD_BYTE, S_LD_WR, S_RUN, S_STEP, S_REPORT, S_ACK
  } state_t;

  localparam logic [7:0]  CMD_L       = 8'h4C;
  localparam logic [7:0]  CMD_R       = 8'h52;
  localparam logic [7:0]  CMD_S       = 8'h53;
  localparam logic [7:0]  CMD_C       = 8'h43;
  localparam logic [7:0]  CMD_ESC     = 8'h1B;
  localparam logic [7:0]  ACK_BYTE    = 8'h4B;
  localparam logic [31:0] WDOG_RESULT = 32'hDEADDEAD;

`ifdef MIPS_RUN_WDOG_EN
  localparam logic WDOG_ON = 1'b1;
`else
  localparam logic WDOG_ON = 1'b0;
`endif

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_left;
  logic [IMEM_AW-1:0] r_idx;
  logic [1:0]         r_bsel;
  logic [31:0]        r_word;
  logic [31:0]        r_result;
  logic [CYCLE_W-1:0] r_cycle;
  logic [2:0]         r_tx_sel;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;
  logic               r_cpu_reset;

  logic [CYCLE_W-1:0] w_cyc_inc;
  logic               w_esc, w_cmd_c, w_wdog_hit, w_enter_report, w_cpu_reset_nxt;

  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Report stream: result bytes 0..3, then the zero-extended cycle count bytes 4..7.
  function automatic logic [7:0] report_byte(input logic [2:0] sel, input logic [31:0] res,
                                             input logic [31:0] cyc);
    logic [63:0] w_all;
    w_all = {cyc, res};
    return w_all[{sel, 3'b000} +: 8];
  endfunction

  assign w_cyc_inc  = sat_inc(r_cycle);
  assign w_esc      = rx_valid && (rx_data == CMD_ESC);
  assign w_cmd_c    = (r_state == S_IDLE) && rx_valid && (rx_data == CMD_C);
  assign w_wdog_hit = WDOG_ON && (32'(w_cyc_inc) >= 32'(MAX_RUN_CYCLES));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_L:   w_state_nxt = S_LD_CNT;
            CMD_R:   w_state_nxt = cpu_halt ? S_REPORT : S_RUN;
            CMD_S:   w_state_nxt = cpu_halt ? S_REPORT : S_STEP;
            CMD_C:   w_state_nxt = S_ACK;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_LD_CNT:  if (rx_valid) w_state_nxt = (rx_data == 8'd0) ? S_ACK : S_LD_BYTE;
      S_LD_BYTE: if (rx_valid && (r_bsel == 2'd3)) w_state_nxt = S_LD_WR;
      S_LD_WR:   w_state_nxt = (r_left == 8'd1) ? S_ACK : S_LD_BYTE;
      S_RUN:     if (cpu_halt || w_esc || w_wdog_hit) w_state_nxt = S_REPORT;
      S_STEP:    w_state_nxt = S_REPORT;
      S_REPORT:  if (r_tx_valid && tx_ready && (r_tx_sel == 3'd7)) w_state_nxt = S_IDLE;
      S_ACK:     if (r_tx_valid && tx_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Core is held in reset for the whole load, and for one cycle on a clear command.
  assign w_cpu_reset_nxt = (w_state_nxt == S_LD_CNT) || (w_state_nxt == S_LD_BYTE) ||
                           (w_state_nxt == S_LD_WR) || w_cmd_c;
  assign w_enter_report  = (w_state_nxt == S_REPORT) && (r_state != S_REPORT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_left      <= '0;
      r_idx       <= '0;
      r_bsel      <= '0;
      r_word      <= '0;
      r_result    <= '0;
      r_cycle     <= '0;
      r_tx_sel    <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      case (r_state)
        S_IDLE: if (w_cmd_c) r_cycle <= '0;
        S_LD_CNT: begin
          if (rx_valid && (rx_data != 8'd0)) begin
            r_left  <= rx_data;
            r_idx   <= '0;
            r_cycle <= '0;
            r_bsel  <= '0;
          end
        end
        S_LD_BYTE: begin
          if (rx_valid) begin
            r_word[{r_bsel, 3'b000} +: 8] <= rx_data;
            r_bsel                        <= r_bsel + 2'd1;
          end
        end
        S_LD_WR: begin
          r_idx  <= r_idx + 1'b1;
          r_left <= r_left - 8'd1;
        end
        S_RUN, S_STEP: r_cycle <= w_cyc_inc;
        default: ;
      endcase

      // A watchdog abort only marks the result when neither halt nor ESC ended the run.
      if (w_enter_report)
        r_result <= ((r_state == S_RUN) && w_wdog_hit && !cpu_halt && !w_esc) ?
                    WDOG_RESULT : cpu_result;

      if ((r_state == S_REPORT) || (r_state == S_ACK)) begin
        if (!r_tx_valid) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= (r_state == S_ACK) ? ACK_BYTE :
                        report_byte(r_tx_sel, r_result, 32'(r_cycle));
        end else if (tx_ready) begin
          if ((r_state == S_ACK) || (r_tx_sel == 3'd7)) begin
            r_tx_valid <= 1'b0;
          end else begin
            r_tx_sel  <= r_tx_sel + 3'd1;
            r_tx_data <= report_byte(r_tx_sel + 3'd1, r_result, 32'(r_cycle));
          end
        end
      end else begin
        r_tx_sel <= '0;
      end
    end
  end

  assign cpu_en     = (r_state == S_RUN) || (r_state == S_STEP);
  assign cpu_reset  = r_cpu_reset;
  assign imem_we    = (r_state == S_LD_WR);
  assign imem_addr  = r_idx;
  assign imem_wdata = r_word;
  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: scoreboarded TX/imem streams, a vector table of
// run/step commands against a small core model, and hand-written load/reset/stall sequences.
`timescale 1ns/1ps
module tb_mips_run_ctrl;
  localparam int AW   = 8;
  localparam int CW   = 10;
  localparam int WDOG = 100;
  localparam int SATV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          cpu_en;
  logic          cpu_reset;
  logic          cpu_halt;
  logic [31:0]   cpu_result;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;

  mips_run_ctrl #(.IMEM_AW(AW), .CYCLE_W(CW), .MAX_RUN_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_en(cpu_en), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .cpu_result(cpu_result),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int             errors = 0;
  int             checks = 0;
  int             en_cnt = 0;
  int             halt_at = 0;
  logic [7:0]     exp_tx[$];
  logic [AW+31:0] exp_wr[$];

  // Host ready: either held by the test or randomised each cycle.
  logic rnd_ready = 1'b0;
  logic rnd_bit   = 1'b1;
  logic ready_hold = 1'b1;
  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));
  assign tx_ready = rnd_ready ? rnd_bit : ready_hold;

  // Core model: counts enabled cycles; halts while executing its halt_at-th cycle.
  int   core_cyc = 0;
  logic halted = 1'b0;
  always @(posedge clk) begin
    if (cpu_reset) begin
      core_cyc <= 0;
      halted   <= 1'b0;
    end else if (cpu_en) begin
      core_cyc <= core_cyc + 1;
      if ((halt_at != 0) && (core_cyc + 1 == halt_at)) halted <= 1'b1;
    end
  end
  assign cpu_halt = halted | ((halt_at != 0) && cpu_en && (core_cyc + 1 == halt_at));

  typedef struct {
    logic [7:0]  cmd;
    logic        pre_c;
    int          halt_at;
    int          esc_at;
    logic [31:0] result;
    int          exp_en;
    int          exp_cnt;
  } vec_t;
  localparam int NV = 9;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e_tx;
    logic [AW+31:0] e_wr;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (cpu_en) en_cnt++;
        if (prev_stall) begin
          chk("tx_hold_valid", tx_valid, 1'b1);
          chk("tx_hold_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got byte %0h with nothing expected", tx_data);
          end else begin
            e_tx = exp_tx.pop_front();
            checks--;
            chk("tx_byte", tx_data, e_tx);
          end
        end
        if (imem_we) begin
          chk("cpu_reset_during_write", cpu_reset, 1'b1);
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL imem_unexpected: got addr %0h data %0h", imem_addr, imem_wdata);
          end else begin
            e_wr = exp_wr.pop_front();
            checks--;
            chk("imem_write", {imem_addr, imem_wdata}, e_wr);
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || (exp_tx.size() != 0) || (exp_wr.size() != 0)) && (n < 5000)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0b pending_tx=%0d pending_wr=%0d, expected idle",
               name, busy, exp_tx.size(), exp_wr.size());
      exp_tx.delete();
      exp_wr.delete();
    end
  endtask

  task automatic push_report(input logic [31:0] res, input logic [31:0] cnt);
    for (int i = 0; i < 4; i++) exp_tx.push_back(res[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_tx.push_back(cnt[8*i +: 8]);
  endtask

  task automatic do_clear();
    exp_tx.push_back(8'h4B);
    send(8'h43);
    wait_done("clear");
  endtask

  task automatic issue_cmd(input logic [7:0] cmd, input int esc_at);
    en_cnt = 0;
    @(negedge clk);
    rx_data  = cmd;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (esc_at > 0) begin
      repeat (esc_at - 1) @(negedge clk);
      rx_data  = 8'h1B;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    chk({tag, "_cpu_en"}, cpu_en, 1'b0);
    chk({tag, "_imem_we"}, imem_we, 1'b0);
    chk({tag, "_imem_addr"}, imem_addr, '0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'h0);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    vt[0] = '{8'h52, 1'b1, 10, 0, 32'h0000_0007, 10, 10};
    vt[1] = '{8'h52, 1'b0,  0, 0, 32'h1122_3344,  0, 10};
    vt[2] = '{8'h53, 1'b1,  0, 0, 32'hA5A5_0001,  1,  1};
    vt[3] = '{8'h53, 1'b0,  0, 0, 32'hA5A5_0002,  1,  2};
    vt[4] = '{8'h53, 1'b0,  0, 0, 32'hA5A5_0003,  1,  3};
    vt[5] = '{8'h52, 1'b0,  7, 0, 32'hCAFE_F00D,  4,  7};
    vt[6] = '{8'h52, 1'b1,  0, 5, 32'h0BAD_BEEF,  5,  5};
    vt[7] = '{8'h52, 1'b1,  3, 3, 32'h8000_0001,  3,  3};
    vt[8] = '{8'h53, 1'b0,  0, 0, 32'h0000_0012,  0,  3};

    reset      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    cpu_result = 32'h0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("release_cpu_reset", cpu_reset, 1'b0);

    send(8'h41);
    send(8'h00);
    chk("idle_ignores_other", busy, 1'b0);

    // Two-word load.
    send(8'h4C);
    chk("load_cpu_reset", cpu_reset, 1'b1);
    send(8'h02);
    send(8'h78); send(8'h56); send(8'h34);
    exp_wr.push_back({8'h00, 32'h1234_5678});
    send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD);
    exp_wr.push_back({8'h01, 32'hDEAD_BEEF});
    exp_tx.push_back(8'h4B);
    send(8'hDE);
    wait_done("load2");
    chk("after_load_cpu_reset", cpu_reset, 1'b0);

    // Empty load: acknowledge only.
    exp_tx.push_back(8'h4B);
    send(8'h4C);
    send(8'h00);
    wait_done("load0");

    // Reset in the middle of the second word of a load.
    send(8'h4C);
    send(8'h02);
    send(8'h01); send(8'h02); send(8'h03);
    exp_wr.push_back({8'h00, 32'h0403_0201});
    send(8'h04);
    send(8'hAA); send(8'hBB);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midload");
    @(negedge clk);
    reset = 1'b1;
    exp_wr.delete();
    send(8'h4C);
    send(8'h01);
    send(8'h11); send(8'h22); send(8'h33);
    exp_wr.push_back({8'h00, 32'h4433_2211});
    exp_tx.push_back(8'h4B);
    send(8'h44);
    wait_done("reload");

    // Vector table with a randomly stalling host.
    rnd_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (vt[i].pre_c) do_clear();
      halt_at    = vt[i].halt_at;
      cpu_result = vt[i].result;
      push_report(vt[i].result, vt[i].exp_cnt);
      issue_cmd(vt[i].cmd, vt[i].esc_at);
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_en_cycles", i), en_cnt, vt[i].exp_en);
    end
    rnd_ready = 1'b0;

    // ESC abort with the host stalled for 20 cycles; an rx byte during REPORT is dropped.
    do_clear();
    halt_at    = 0;
    cpu_result = 32'h5A5A_A5A5;
    ready_hold = 1'b0;
    push_report(32'h5A5A_A5A5, 5);
    issue_cmd(8'h52, 5);
    n = 0;
    while (!tx_valid && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk("stall_tx_valid", tx_valid, 1'b1);
    send(8'h53);
    repeat (18) @(negedge clk);
    ready_hold = 1'b1;
    wait_done("stall");
    chk("stall_en_cycles", en_cnt, 5);

`ifdef MIPS_RUN_WDOG_EN
    do_clear();
    halt_at    = 0;
    cpu_result = 32'h0000_0001;
    push_report(32'hDEAD_DEAD, WDOG);
    issue_cmd(8'h52, 0);
    wait_done("wdog");
    chk("wdog_en_cycles", en_cnt, WDOG);
`else
    do_clear();
    halt_at    = SATV + 7;
    cpu_result = 32'h0000_5A7E;
    push_report(32'h0000_5A7E, SATV);
    issue_cmd(8'h52, 0);
    wait_done("saturate");
    chk("saturate_en_cycles", en_cnt, SATV + 7);
`endif

    repeat (20) @(negedge clk);
    chk("final_idle", busy, 1'b0);
    chk("final_no_tx", tx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
